// File: rtl/ysyx_22051013_mem_arbiter.sv
// Round-robin arbiter between icache refills and dcache/LSU accesses
// in front of the single AXI bridge, with a sticky response watchdog.
//
// Ports:
//   clk, rst                    clock, sync active-high reset
//   i_ena/i_addr                icache request (level, read only)
//   i_rdata/i_valid             icache response (valid is a 1-cycle pulse)
//   d_ena/d_we/d_addr/
//   d_wdata/d_wstrb             dcache request (level)
//   d_rdata/d_valid             dcache response (also acks writes)
//   mem_ena/mem_we/mem_addr/
//   mem_wdata/mem_wstrb         latched request towards the bridge
//   mem_rdata/mem_valid         bridge response
//   grant_owner                 00 none, 01 icache, 10 dcache
//   err                         sticky watchdog timeout flag
module ysyx_22051013_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ena,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  input  logic                d_ena,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_ena,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_valid,
  output logic [1:0]          grant_owner,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [16:0] TO = 17'(TIMEOUT);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [1:0]          own_q, own_d;
  logic                pick_i, pick_d;
  logic                in_grant;

  // last_q: 0 = icache was granted last, 1 = dcache
  assign pick_i = i_ena & (~d_ena | last_q);
  assign pick_d = d_ena & (~i_ena | ~last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d = GRANT_I;
          last_d  = 1'b0;
          we_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
          wstrb_d = '0;
          cnt_d   = '0;
        end else if (pick_d) begin
          state_d = GRANT_D;
          last_d  = 1'b1;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wstrb_d = d_wstrb;
          cnt_d   = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_valid) begin
          state_d = RELEASE;
        end else begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if ({1'b0, cnt_q} + 17'd1 >= TO) err_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_d = 2'b00;
    if (state_d == GRANT_I) own_d = 2'b01;
    if (state_d == GRANT_D) own_d = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      own_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      own_q   <= own_d;
    end
  end

  assign in_grant    = (state_q == GRANT_I) | (state_q == GRANT_D);
  assign mem_ena     = in_grant & ~mem_valid;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign i_valid     = (state_q == GRANT_I) & mem_valid;
  assign d_valid     = (state_q == GRANT_D) & mem_valid;
  assign i_rdata     = i_valid ? mem_rdata : '0;
  assign d_rdata     = d_valid ? mem_rdata : '0;
  assign grant_owner = own_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// Directed bench for the icache/dcache memory arbiter.
// Inputs change on negedge; outputs checked 1ns later.
module tb_ysyx_22051013_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ena;
  logic [63:0] i_addr;
  logic [63:0] i_rdata;
  logic        i_valid;
  logic        d_ena;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic [63:0] d_rdata;
  logic        d_valid;
  logic        mem_ena;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata;
  logic        mem_valid;
  logic [1:0]  grant_owner;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ysyx_22051013_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ena(i_ena), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_valid(i_valid),
    .d_ena(d_ena), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_ena(mem_ena), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .grant_owner(grant_owner), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [1:0] exp_own [4];
  int n;

  initial begin
    exp_own[0] = 2'b10;
    exp_own[1] = 2'b01;
    exp_own[2] = 2'b10;
    exp_own[3] = 2'b01;

    rst = 1'b1; i_ena = 0; i_addr = '0;
    d_ena = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0;
    mem_rdata = '0; mem_valid = 0;
    cyc(); cyc();
    #1;
    chk("rst_ena", 64'(mem_ena), 0);
    chk("rst_own", 64'(grant_owner), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;

    // single icache read
    cyc();
    i_ena = 1; i_addr = 64'h8000_0010;
    cyc(); #1;
    chk("ir_ena1", 64'(mem_ena), 1);
    chk("ir_addr", mem_addr, 64'h8000_0010);
    chk("ir_we", 64'(mem_we), 0);
    chk("ir_own", 64'(grant_owner), 1);
    chk("ir_val0", 64'(i_valid), 0);
    cyc(); #1;
    chk("ir_ena2", 64'(mem_ena), 1);
    cyc();
    mem_valid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("ir_valid", 64'(i_valid), 1);
    chk("ir_rdata", i_rdata, 64'h1234_5678_9ABC_DEF0);
    chk("ir_dval", 64'(d_valid), 0);
    chk("ir_drd", d_rdata, 0);
    chk("ir_ena3", 64'(mem_ena), 0);
    i_ena = 0;
    cyc();
    mem_valid = 0;
    #1;
    chk("ir_rel_own", 64'(grant_owner), 0);
    chk("ir_rel_ena", 64'(mem_ena), 0);
    chk("ir_rel_val", 64'(i_valid), 0);
    cyc();

    // dcache write, requester address change after grant
    d_ena = 1; d_we = 1; d_addr = 64'h8000_1000;
    d_wdata = 64'hAA; d_wstrb = 8'h01;
    cyc(); #1;
    chk("dw_we", 64'(mem_we), 1);
    chk("dw_addr", mem_addr, 64'h8000_1000);
    chk("dw_wdata", mem_wdata, 64'hAA);
    chk("dw_wstrb", 64'(mem_wstrb), 1);
    chk("dw_own", 64'(grant_owner), 2);
    d_addr = 64'hDEAD;
    cyc(); #1;
    chk("dw_hold", mem_addr, 64'h8000_1000);
    cyc();
    mem_valid = 1; mem_rdata = 64'h55;
    #1;
    chk("dw_dval", 64'(d_valid), 1);
    chk("dw_ival", 64'(i_valid), 0);
    chk("dw_drd", d_rdata, 64'h55);
    d_ena = 0; d_we = 0;
    cyc(); mem_valid = 0;
    cyc(); cyc();

    // contention from reset
    rst = 1; i_ena = 1; d_ena = 1; d_addr = 64'h40;
    i_addr = 64'h80;
    cyc(); cyc();
    rst = 0;
    cyc(); #1;
    chk("ct_own0", 64'(grant_owner), 64'(exp_own[0]));
    chk("ct_ena0", 64'(mem_ena), 1);
    for (int g = 0; g < 4; g++) begin
      cyc();
      mem_valid = 1;
      #1;
      if (exp_own[g] == 2'b01) begin
        chk("ct_ival", 64'(i_valid), 1);
        chk("ct_dval", 64'(d_valid), 0);
      end else begin
        chk("ct_dval", 64'(d_valid), 1);
        chk("ct_ival", 64'(i_valid), 0);
      end
      if (g == 3) begin
        i_ena = 0; d_ena = 0;
      end
      n = 0;
      do begin
        cyc();
        mem_valid = 0;
        n++;
        #1;
      end while (!mem_ena && n < 10);
      if (g < 3) begin
        chk("ct_gap", 64'(n), 3);
        chk("ct_own", 64'(grant_owner), 64'(exp_own[g+1]));
      end else begin
        chk("ct_idle", 64'(mem_ena), 0);
      end
    end

    // watchdog timeout
    rst = 1;
    cyc();
    rst = 0; d_ena = 1; d_we = 0; d_addr = 64'h100;
    for (int k = 1; k <= 8; k++) begin
      cyc(); #1;
      if (k == 1) chk("to_own", 64'(grant_owner), 2);
      if (k == 8) chk("to_err7", 64'(err), 0);
    end
    cyc(); #1;
    chk("to_err8", 64'(err), 1);
    cyc(); cyc(); #1;
    chk("to_sticky", 64'(err), 1);
    chk("to_wait", 64'(mem_ena), 1);
    cyc();
    mem_valid = 1; mem_rdata = 64'h77;
    #1;
    chk("to_dval", 64'(d_valid), 1);
    d_ena = 0;
    cyc(); mem_valid = 0;
    cyc(); cyc(); #1;
    chk("to_keep", 64'(err), 1);
    rst = 1;
    cyc(); #1;
    chk("to_clr", 64'(err), 0);
    rst = 0;

    // reset during dcache grant
    cyc();
    d_ena = 1; d_addr = 64'h200;
    cyc(); #1;
    chk("rg_own", 64'(grant_owner), 2);
    rst = 1;
    cyc();
    rst = 0; d_ena = 0;
    #1;
    chk("rg_ena", 64'(mem_ena), 0);
    chk("rg_own0", 64'(grant_owner), 0);
    mem_valid = 1;
    #1;
    chk("rg_stray", 64'(d_valid), 0);
    chk("rg_stray_i", 64'(i_valid), 0);
    cyc(); mem_valid = 0;
    #1;
    chk("rg_idle", 64'(mem_ena), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
